uart_frame_writer: RTL and testbench

//  Write-side client of the shared UART controller. Requests the transmit lock on one lock port
//  and waits for the grant. Then streams one framed message, SYNC | LEN | PAYLOAD[LEN] | CSUM,
//  and releases the lock. Payload bytes come from an upstream valid/ready byte stream, e.g. the

---
 rtl/uart_frame_writer.sv | 152 +++++++++++++++
 tb/tb_uart_frame_writer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_writer.sv
// Write-side client of the shared UART controller: takes the transmit lock, then streams one
// SYNC | LEN | PAYLOAD | CSUM frame and releases the lock.
module uart_frame_writer #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int          MAX_LEN      = 255,
    parameter int          LOCK_TIMEOUT = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic [7:0] payload_in,
    input  logic       payload_valid,
    output logic       payload_ready,
    output logic       lock_req,
    input  logic       lock_grant,
    input  logic       write_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOCK, S_HDR, S_LEN, S_PAYLOAD, S_CSUM, S_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    rem_q, rem_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          lock_req_q, lock_req_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          accept;

    // Payload bytes pass straight through so the upstream handshake equals the byte accept.
    always_comb begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        case (state_q)
            S_HDR:     begin tx_data = SYNC_BYTE;  tx_valid = 1'b1;          end
            S_LEN:     begin tx_data = len_q;      tx_valid = 1'b1;          end
            S_PAYLOAD: begin tx_data = payload_in; tx_valid = payload_valid; end
            S_CSUM:    begin tx_data = csum_q;     tx_valid = 1'b1;          end
            default:   begin tx_data = 8'h00;      tx_valid = 1'b0;          end
        endcase
    end

    assign payload_ready = (state_q == S_PAYLOAD) & write_ready & lock_grant;
    assign accept        = tx_valid & write_ready & lock_grant;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        rem_d   = rem_q;
        csum_d  = csum_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (int'(frame_len) > MAX_LEN) begin
                        error_d = 1'b1;
                    end else begin
                        len_d   = frame_len;
                        csum_d  = 8'h00;
                        tmo_d   = '0;
                        state_d = S_LOCK;
                    end
                end
            end
            S_LOCK: begin
                if (lock_grant) begin
                    state_d = S_HDR;
                end else if (LOCK_TIMEOUT != 0 && tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_HDR, S_LEN, S_PAYLOAD, S_CSUM: begin
                // Guard only: the controller is not expected to revoke a held lock.
                if (!lock_grant) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (accept) begin
                    case (state_q)
                        S_HDR: state_d = S_LEN;
                        S_LEN: begin
                            csum_d  = len_q;
                            rem_d   = len_q;
                            state_d = (len_q != 8'h00) ? S_PAYLOAD : S_CSUM;
                        end
                        S_PAYLOAD: begin
                            csum_d = csum_q + payload_in;
                            rem_d  = rem_q - 8'h01;
                            if (rem_q == 8'h01) state_d = S_CSUM;
                        end
                        default: state_d = S_RELEASE;
                    endcase
                end
            end
            S_RELEASE: begin
                if (!lock_grant) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        lock_req_d = (state_d == S_LOCK) || (state_d == S_HDR) || (state_d == S_LEN) ||
                     (state_d == S_PAYLOAD) || (state_d == S_CSUM);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= 8'h00;
            rem_q      <= 8'h00;
            csum_q     <= 8'h00;
            tmo_q      <= '0;
            lock_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            csum_q     <= csum_d;
            tmo_q      <= tmo_d;
            lock_req_q <= lock_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign lock_req = lock_req_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
endmodule

// File: tb/tb_uart_frame_writer.sv
// Directed bench for uart_frame_writer with a small lock/controller model and a byte scoreboard.
module tb_uart_frame_writer;
    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] frame_len;
    logic [7:0] payload_in;
    logic       payload_valid;
    logic       payload_ready;
    logic       lock_req;
    logic       lock_grant;
    logic       write_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic       done;
    logic       error;

    uart_frame_writer #(.SYNC_BYTE(8'hA5), .MAX_LEN(8), .LOCK_TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .start(start), .frame_len(frame_len),
        .payload_in(payload_in), .payload_valid(payload_valid), .payload_ready(payload_ready),
        .lock_req(lock_req), .lock_grant(lock_grant), .write_ready(write_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pay_q[$];
    int         pay_idx, done_cnt, err_cnt, cyc, lock_rise_cyc, err_cyc;
    bit         grant_en, toggle_wr, gap_mode;
    bit         pready_seen, txv_seen, lock_any, lock_seen;
    bit         hold_flag, rel_pend;
    logic [7:0] hold_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample at negedge, then update the controller/upstream model after posedge.
    task automatic step();
        logic acc;
        @(negedge clock);
        cyc++;
        acc = tx_valid & write_ready & lock_grant;
        if (hold_flag && tx_valid) chk("tx_data_stable", tx_data, hold_data);
        hold_flag = tx_valid & ~acc;
        hold_data = tx_data;
        if (rel_pend) begin
            chk("lock_req_fall", lock_req, 0);
            rel_pend = 0;
        end
        if (acc) begin
            if (exp_q.size() == 0) begin
                chk("byte_expected", (exp_q.size() != 0), 1);
            end else begin
                chk("tx_byte", tx_data, exp_q.pop_front());
                if (exp_q.size() == 0) rel_pend = 1;
            end
        end
        if (payload_valid & payload_ready) pay_idx++;
        if (payload_ready) pready_seen = 1;
        if (tx_valid) txv_seen = 1;
        if (lock_req) lock_any = 1;
        if (lock_req && lock_rise_cyc < 0) lock_rise_cyc = cyc;
        if (done) done_cnt++;
        if (error) begin
            err_cnt++;
            if (err_cyc < 0) err_cyc = cyc;
        end
        if (done | error) chk("done_error_excl", done & error, 0);
        lock_seen = lock_req;
        @(posedge clock);
        #1;
        lock_grant  = grant_en & lock_seen;
        write_ready = toggle_wr ? ~write_ready : 1'b1;
        if (pay_idx < pay_q.size()) begin
            payload_in    = pay_q[pay_idx];
            payload_valid = gap_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end else begin
            payload_in    = 8'h00;
            payload_valid = 1'b0;
        end
    endtask

    task automatic clear_track();
        done_cnt = 0; err_cnt = 0; pay_idx = 0;
        pready_seen = 0; txv_seen = 0; lock_any = 0;
        lock_rise_cyc = -1; err_cyc = -1;
        hold_flag = 0; rel_pend = 0;
    endtask

    // stop >= 0 abandons the frame once that many payload bytes have been consumed.
    task automatic run_frame(input int len, input bit rnd, input int stop);
        logic [7:0] csum;
        clear_track();
        pay_q.delete();
        exp_q.delete();
        csum = 8'(len);
        for (int i = 0; i < len; i++) begin
            pay_q.push_back(rnd ? 8'($urandom) : 8'(i + 1));
            csum = csum + pay_q[i];
        end
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(len));
        for (int i = 0; i < len; i++) exp_q.push_back(pay_q[i]);
        exp_q.push_back(csum);
        start     = 1'b1;
        frame_len = 8'(len);
        step();
        start     = 1'b0;
        for (int i = 0; i < 300 && done_cnt == 0; i++) begin
            step();
            if (stop >= 0 && pay_idx >= stop) break;
        end
        if (stop < 0) begin
            chk("frame_done", done_cnt, 1);
            chk("frame_no_error", err_cnt, 0);
            chk("frame_bytes_left", exp_q.size(), 0);
            chk("payload_consumed", pay_idx, len);
            if (len == 0) chk("len0_no_payload_ready", pready_seen, 0);
            step();
            chk("done_single_pulse", done_cnt, 1);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; frame_len = 8'h00;
        payload_in = 8'h00; payload_valid = 1'b0;
        lock_grant = 1'b0; write_ready = 1'b1;
        grant_en = 1; toggle_wr = 0; gap_mode = 0; cyc = 0; lock_seen = 0;
        clear_track();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        step();
        chk("rst_lock_req", lock_req, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_payload_ready", payload_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);

        // Basic frame A5 03 01 02 03 09.
        run_frame(3, 0, -1);

        // Back-pressure from the controller and a gapped upstream.
        toggle_wr = 1; gap_mode = 1;
        run_frame(3, 0, -1);
        run_frame(6, 1, -1);
        toggle_wr = 0; gap_mode = 0;
        repeat (2) step();

        run_frame(0, 0, -1);
        run_frame(8, 1, -1);

        // Lock never granted: timeout abort.
        grant_en = 0;
        clear_track();
        start = 1'b1; frame_len = 8'd2;
        step();
        start = 1'b0;
        for (int i = 0; i < 40 && err_cnt == 0; i++) step();
        chk("timeout_latency", err_cyc - lock_rise_cyc, 16);
        chk("timeout_lock_req_low", lock_seen, 0);
        repeat (3) step();
        chk("timeout_single_error", err_cnt, 1);
        chk("timeout_no_tx_valid", txv_seen, 0);
        chk("timeout_busy", busy, 0);
        grant_en = 1;

        // Oversize length rejected without touching the lock.
        clear_track();
        start = 1'b1; frame_len = 8'd10;
        step();
        start = 1'b0;
        step();
        chk("oversize_error_next_cycle", err_cnt, 1);
        repeat (3) step();
        chk("oversize_no_lock_req", lock_any, 0);
        chk("oversize_single_error", err_cnt, 1);
        chk("oversize_busy", busy, 0);

        // Async reset mid-payload, then a fresh frame.
        run_frame(5, 1, 2);
        chk("pre_reset_lock_req", lock_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("midreset_lock_req", lock_req, 0);
        chk("midreset_tx_valid", tx_valid, 0);
        chk("midreset_busy", busy, 0);
        exp_q.delete();
        pay_q.delete();
        hold_flag = 0; rel_pend = 0;
        step();
        step();
        reset = 1'b0;
        repeat (2) step();
        run_frame(5, 1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
